// File: rtl/dc_offset_corr_if.sv
// Purpose : bundles the sample stream, accumulator hand-off and status of dc_offset_corr.
// Latency : n/a (wiring only).
// Backpressure: none; the stream is qualified by clk_en and has no ready.
//
// Signals:
//   clk_en        symbol-rate enable
//   enable        loop enable; low forces IDLE
//   sample_in     uncorrected sample (signed 18)
//   acc_dc_err_in window-average DC error from the accumulator (signed 18)
//   hold_out      one-clk clear pulse to the accumulator
//   sample_out    corrected sample (signed 18)
//   dc_offset     current offset estimate (signed 18)
//   locked        high in TRACK
//   state_out     IDLE=0, DISCARD=1, ACQUIRE=2, TRACK=3
interface dc_offset_corr_if;
  logic               clk_en;
  logic               enable;
  logic signed [17:0] sample_in;
  logic signed [17:0] acc_dc_err_in;
  logic               hold_out;
  logic signed [17:0] sample_out;
  logic signed [17:0] dc_offset;
  logic               locked;
  logic [1:0]         state_out;

  // Driver side (stimulus / upstream datapath).
  modport master (
    output clk_en, enable, sample_in, acc_dc_err_in,
    input  hold_out, sample_out, dc_offset, locked, state_out
  );

  // Correction block side.
  modport slave (
    input  clk_en, enable, sample_in, acc_dc_err_in,
    output hold_out, sample_out, dc_offset, locked, state_out
  );
endinterface

// File: rtl/dc_offset_corr.sv
// Purpose : windowed DC offset estimator and subtractor ahead of the slicer, with acquire/track FSM.
// Latency : sample_out is one clk_en tick behind sample_in; estimate updates once per window.
// Backpressure: none; all state advances on clk_en, outputs hold while clk_en is low.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, clears all state
//   bus    dc_offset_corr_if.slave (stream in/out, accumulator hand-off, status)

`ifndef LFSR_LEN
`define LFSR_LEN 7
`endif

module dc_offset_corr #(
  parameter int WIN_LOG2     = `LFSR_LEN,
  parameter int ACQ_WINDOWS  = 4,
  parameter int MU_ACQ       = 1,
  parameter int MU_TRK       = 4,
  parameter int LOSS_THR     = 2048,
  parameter int LOSS_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             reset,
  dc_offset_corr_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DISCARD = 2'd1;
  localparam logic [1:0] S_ACQUIRE = 2'd2;
  localparam logic [1:0] S_TRACK   = 2'd3;

  // Counters only need to reach N-1; the transition fires on that value.
  localparam int ACQ_W  = (ACQ_WINDOWS  > 1) ? $clog2(ACQ_WINDOWS)  : 1;
  localparam int LOSS_W = (LOSS_WINDOWS > 1) ? $clog2(LOSS_WINDOWS) : 1;

  // Clamp a 19-bit two's-complement value into the signed 18-bit range.
  // Overflow is exactly when the two top bits disagree.
  function automatic logic [17:0] sat18(input logic [18:0] v);
    if (v[18] != v[17]) begin
      sat18 = v[18] ? 18'h20000 : 18'h1FFFF;
    end else begin
      sat18 = v[17:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic                r_locked;
  logic [WIN_LOG2-1:0] r_cnt;
  logic                r_hold;
  logic [ACQ_W-1:0]    r_acq_cnt;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic signed [17:0]  r_dc;
  logic signed [17:0]  r_sample;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [17:0] w_est;
  logic [17:0]        w_est_u;
  logic signed [17:0] w_step_acq;
  logic signed [17:0] w_step_trk;
  logic [18:0]        w_sum_acq;
  logic [18:0]        w_sum_trk;
  logic [18:0]        w_diff;
  logic [17:0]        w_abs_est;
  logic               w_loss;

  assign w_est      = bus.acc_dc_err_in;
  assign w_est_u    = bus.acc_dc_err_in;
  assign w_step_acq = w_est >>> MU_ACQ;
  assign w_step_trk = w_est >>> MU_TRK;

  // Sign-extend both operands to 19 bits so the sum/difference cannot wrap.
  assign w_sum_acq = {r_dc[17], r_dc} + {w_step_acq[17], w_step_acq};
  assign w_sum_trk = {r_dc[17], r_dc} + {w_step_trk[17], w_step_trk};
  assign w_diff    = {bus.sample_in[17], bus.sample_in} - {r_dc[17], r_dc};

  // Saturating |est|: the most negative code has no positive twin, so it
  // folds onto the largest positive value.
  assign w_abs_est = !w_est_u[17]           ? w_est_u :
                     (w_est_u == 18'h20000) ? 18'h1FFFF :
                                              (~w_est_u + 18'd1);
  assign w_loss    = (w_abs_est > 18'(LOSS_THR));

  // ---------------------------------------------------------------------------
  // Window timing
  // ---------------------------------------------------------------------------
  logic w_terminal;
  logic w_upd;
  logic w_acq_last;
  logic w_loss_last;

  assign w_terminal  = bus.clk_en && (r_cnt == '1);
  // Update event: first clk_en tick of a window. A falling enable suppresses it.
  assign w_upd       = bus.enable && (r_state != S_IDLE) && bus.clk_en && (r_cnt == '0);
  assign w_acq_last  = (r_acq_cnt  == ACQ_W'(ACQ_WINDOWS - 1));
  assign w_loss_last = (r_loss_cnt == LOSS_W'(LOSS_WINDOWS - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [1:0] w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = S_DISCARD;
    end else if (w_upd) begin
      case (r_state)
        // Accumulator still holds data from before the restart; skip it.
        S_DISCARD: w_state_nxt = S_ACQUIRE;
        S_ACQUIRE: if (w_acq_last) w_state_nxt = S_TRACK;
        S_TRACK:   if (w_loss && w_loss_last) w_state_nxt = S_ACQUIRE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_locked   <= 1'b0;
      r_cnt      <= '0;
      r_hold     <= 1'b0;
      r_acq_cnt  <= '0;
      r_loss_cnt <= '0;
      r_dc       <= '0;
      r_sample   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == S_TRACK);
      r_hold   <= 1'b0;

      // Correction runs in every state, IDLE included, using the held estimate.
      if (bus.clk_en) begin
        r_sample <= sat18(w_diff);
      end

      if (!bus.enable) begin
        r_cnt      <= '0;
        r_acq_cnt  <= '0;
        r_loss_cnt <= '0;
      end else if (r_state == S_IDLE) begin
        // Leaving IDLE: start a fresh window and clear the accumulator.
        r_cnt      <= '0;
        r_hold     <= 1'b1;
        r_acq_cnt  <= '0;
        r_loss_cnt <= '0;
      end else if (bus.clk_en) begin
        r_cnt  <= r_cnt + 1'b1;
        r_hold <= w_terminal;
        if (w_upd) begin
          case (r_state)
            S_ACQUIRE: begin
              r_dc      <= sat18(w_sum_acq);
              r_acq_cnt <= w_acq_last ? '0 : r_acq_cnt + 1'b1;
            end
            S_TRACK: begin
              // The estimate is still applied in a window that triggers loss.
              r_dc <= sat18(w_sum_trk);
              if (!w_loss) begin
                r_loss_cnt <= '0;
              end else if (w_loss_last) begin
                r_loss_cnt <= '0;
                r_acq_cnt  <= '0;
              end else begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.hold_out   = r_hold;
  assign bus.sample_out = r_sample;
  assign bus.dc_offset  = r_dc;
  assign bus.locked     = r_locked;
  assign bus.state_out  = r_state;

endmodule
